// File: rtl/nap_pkg.sv
// nap_pkg: shared types and constants for the nap timer.
// State encoding, keypad codes and the seconds-per-minute constant.
package nap_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MANUAL = 3'd1,
    S_READY  = 3'd2,
    S_COUNT  = 3'd3,
    S_DONE   = 3'd4,
    S_PAUSE  = 3'd5
  } napState_t;

  localparam logic [3:0] KEY_STAR    = 4'hA;
  localparam logic [3:0] KEY_SHARP   = 4'hB;
  localparam logic [5:0] SEC_PER_MIN = 6'd60;

  // Keypad codes 0..9 are decimal digits.
  function automatic logic isDigit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/nap_prescaler.sv
// nap_prescaler: divides the system clock down to a one-second tick.
// tick is a one-cycle pulse on every CLK_HZ-th cycle spent running.
// clear restarts the count; holding run low freezes it in place.
module nap_prescaler #(
  parameter int CLK_HZ = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;

  assign tick = run && (count == LAST);

  // Cycle counter: wraps on tick, frozen while not running, zeroed by clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= tick ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/nap_timer.sv
// nap_timer: nap duration setting (auto or keypad) and real-time countdown.
// Build macro NAP_PAUSE_EN adds a PAUSE state: '*' toggles COUNT <-> PAUSE,
// freezing the prescaler and counters while paused.
module nap_timer
  import nap_pkg::*;
#(
  parameter int CLK_HZ   = 1000,
  parameter int AUTO_MIN = 20,
  parameter int MAX_MIN  = 99
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init,
  input  logic       enAutoSetting,
  input  logic       enManualSetting,
  input  logic       enSleep,
  input  logic       enCancel,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  output logic       completeSetting,
  output logic       completeSleep,
  output logic [6:0] minLeft,
  output logic [5:0] secLeft,
  output logic [2:0] stateDbg
);

  // Handshake: keyValid is a one-cycle strobe qualifying keyCode with no
  // back-pressure; each strobe is consumed on the edge that samples it and is
  // interpreted in the state held before that edge. Phase enables are levels
  // and act only in the state they apply to, so holding one never repeats it.

  localparam logic [6:0] AUTO_VAL = 7'(AUTO_MIN);
  localparam logic [6:0] MAX_VAL  = 7'(MAX_MIN);

  napState_t  state, nextState;
  logic [6:0] entryBuf, nextBuf;
  logic [6:0] duration, nextDuration;
  logic [6:0] minCnt, nextMin;
  logic [5:0] secCnt, nextSec;
  logic       abort, tick, preClear, preRun, keyStar;

  assign abort    = init | enCancel;
  assign keyStar  = keyValid && (keyCode == KEY_STAR);
  assign preRun   = (state == S_COUNT);
  // Prescaler keeps its phase across PAUSE and restarts everywhere else.
  assign preClear = abort || !((state == S_COUNT) || (state == S_PAUSE));
  assign stateDbg = state;

  nap_prescaler #(.CLK_HZ(CLK_HZ)) uPrescaler (
    .clock(clock),
    .reset(reset),
    .clear(preClear),
    .run  (preRun),
    .tick (tick)
  );

  // Next-state and datapath update; abort outranks everything, including a tick.
  always_comb begin
    nextState    = state;
    nextBuf      = entryBuf;
    nextDuration = duration;
    nextMin      = minCnt;
    nextSec      = secCnt;
    if (abort) begin
      nextState    = S_IDLE;
      nextBuf      = '0;
      nextDuration = '0;
      nextMin      = '0;
      nextSec      = '0;
    end else begin
      case (state)
        S_IDLE: begin
          // enSleep outranks the setting requests but has nothing to start here.
          if (!enSleep) begin
            if (enManualSetting) begin
              nextBuf   = '0;
              nextState = S_MANUAL;
            end else if (enAutoSetting) begin
              nextDuration = AUTO_VAL;
              nextState    = S_READY;
            end
          end
        end
        S_MANUAL: begin
          if (keyValid && isDigit(keyCode)) begin
            // Keep only the last two digits typed.
            nextBuf = (entryBuf % 7'd10) * 7'd10 + {3'b000, keyCode};
          end else if (keyStar) begin
            nextBuf = '0;
          end else if (keyValid && (keyCode == KEY_SHARP)) begin
            if ((entryBuf != '0) && (entryBuf <= MAX_VAL)) begin
              nextDuration = entryBuf;
              nextState    = S_READY;
            end else begin
              nextBuf = '0;
            end
          end
        end
        S_READY: begin
          if (enSleep) begin
            nextMin   = duration;
            nextSec   = '0;
            nextState = S_COUNT;
          end
        end
        S_COUNT: begin
          if (tick) begin
            if (secCnt == '0) begin
              nextSec = SEC_PER_MIN - 6'd1;
              nextMin = minCnt - 7'd1;
            end else begin
              nextSec = secCnt - 6'd1;
            end
            // 0:01 -> 0:00 is the only decrement that ends the nap.
            if ((minCnt == '0) && (secCnt == 6'd1)) begin
              nextState = S_DONE;
            end
          end
`ifdef NAP_PAUSE_EN
          if ((nextState == S_COUNT) && keyStar) begin
            nextState = S_PAUSE;
          end
`endif
        end
`ifdef NAP_PAUSE_EN
        S_PAUSE: begin
          if (keyStar) begin
            nextState = S_COUNT;
          end
        end
`endif
        S_DONE:  nextState = S_DONE;
        default: nextState = S_IDLE;
      endcase
    end
  end

  // State and datapath registers; completion flags are registered from the FSM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      entryBuf        <= '0;
      duration        <= '0;
      minCnt          <= '0;
      secCnt          <= '0;
      completeSetting <= 1'b0;
      completeSleep   <= 1'b0;
    end else begin
      state           <= nextState;
      entryBuf        <= nextBuf;
      duration        <= nextDuration;
      minCnt          <= nextMin;
      secCnt          <= nextSec;
      completeSetting <= (nextState == S_READY);
      completeSleep   <= (state == S_DONE) && (nextState == S_DONE);
    end
  end

  // Display mux: entry buffer while typing, chosen duration while ready.
  always_comb begin
    minLeft = minCnt;
    secLeft = secCnt;
    if (state == S_MANUAL) begin
      minLeft = entryBuf;
    end else if (state == S_READY) begin
      minLeft = duration;
    end
  end

endmodule

// File: tb/tb_nap_timer.sv
// tb_nap_timer: scoreboard bench for nap_timer (CLK_HZ=4, AUTO_MIN=2, MAX_MIN=50).
// The driver advances a behavioural model one clock at a time and queues every
// predicted change of the output vector with its cycle stamp; the monitor pops
// and compares whenever the DUT's outputs change.
`timescale 1ns/1ps
module tb_nap_timer;
  import nap_pkg::*;

  localparam int CLK_HZ   = 4;
  localparam int AUTO_MIN = 2;
  localparam int MAX_MIN  = 50;
  localparam int W        = 18;

  localparam logic [4:0] EN_NONE   = 5'b00000;
  localparam logic [4:0] EN_INIT   = 5'b10000;
  localparam logic [4:0] EN_AUTO   = 5'b01000;
  localparam logic [4:0] EN_MAN    = 5'b00100;
  localparam logic [4:0] EN_SLEEP  = 5'b00010;
  localparam logic [4:0] EN_CANCEL = 5'b00001;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic init = 1'b0, enAutoSetting = 1'b0, enManualSetting = 1'b0;
  logic enSleep = 1'b0, enCancel = 1'b0, keyValid = 1'b0;
  logic [3:0] keyCode = 4'h0;
  logic completeSetting, completeSleep;
  logic [6:0] minLeft;
  logic [5:0] secLeft;
  logic [2:0] stateDbg;

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  nap_timer #(.CLK_HZ(CLK_HZ), .AUTO_MIN(AUTO_MIN), .MAX_MIN(MAX_MIN)) dut (
    .clock(clock), .reset(reset), .init(init), .enAutoSetting(enAutoSetting),
    .enManualSetting(enManualSetting), .enSleep(enSleep), .enCancel(enCancel),
    .keyValid(keyValid), .keyCode(keyCode), .completeSetting(completeSetting),
    .completeSleep(completeSleep), .minLeft(minLeft), .secLeft(secLeft),
    .stateDbg(stateDbg)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int unsigned  stamp_q[$];
  string        name_q[$];
  int tests = 0;
  int failures = 0;
  string phase = "reset";

  // ---------------- reference model ----------------
  napState_t m_st = S_IDLE;
  int m_buf = 0, m_dur = 0, m_rem = 0, m_elapsed = 0;
  logic m_sleep_out = 1'b0;
  logic [W-1:0] last_vec = '1;

  function automatic logic [W-1:0] model_vec();
    int mn, sc;
    mn = 0;
    sc = 0;
    if (m_st == S_MANUAL) mn = m_buf;
    else if (m_st == S_READY) mn = m_dur;
    else if (m_st == S_COUNT || m_st == S_PAUSE || m_st == S_DONE) begin
      mn = m_rem / 60;
      sc = m_rem % 60;
    end
    return {(m_st == S_READY), m_sleep_out, 7'(mn), 6'(sc), m_st};
  endfunction

  function automatic void model_push(input int unsigned stamp);
    logic [W-1:0] v;
    v = model_vec();
    if (v !== last_vec) begin
      exp_q.push_back(v);
      stamp_q.push_back(stamp);
      name_q.push_back(phase);
    end
    last_vec = v;
  endfunction

  function automatic void model_clear();
    m_st = S_IDLE;
    m_buf = 0;
    m_dur = 0;
    m_rem = 0;
    m_elapsed = 0;
  endfunction

  // Advance the model over one rising edge using the inputs currently driven.
  function automatic void model_edge();
    napState_t prev;
    prev = m_st;
    if (init || enCancel) begin
      model_clear();
    end else begin
      case (m_st)
        S_IDLE: begin
          if (!enSleep && enManualSetting) begin
            m_buf = 0;
            m_st = S_MANUAL;
          end else if (!enSleep && enAutoSetting) begin
            m_dur = AUTO_MIN;
            m_st = S_READY;
          end
        end
        S_MANUAL: begin
          if (keyValid) begin
            if (keyCode < 4'd10) m_buf = (m_buf % 10) * 10 + int'(keyCode);
            else if (keyCode == KEY_STAR) m_buf = 0;
            else if (keyCode == KEY_SHARP) begin
              if (m_buf >= 1 && m_buf <= MAX_MIN) begin
                m_dur = m_buf;
                m_st = S_READY;
              end else m_buf = 0;
            end
          end
        end
        S_READY: begin
          if (enSleep) begin
            m_rem = m_dur * 60;
            m_elapsed = 0;
            m_st = S_COUNT;
          end
        end
        S_COUNT: begin
          m_elapsed++;
          if (m_elapsed % CLK_HZ == 0) m_rem--;
          if (m_rem == 0) m_st = S_DONE;
`ifdef NAP_PAUSE_EN
          else if (keyValid && keyCode == KEY_STAR) m_st = S_PAUSE;
`endif
        end
        S_PAUSE: begin
          if (keyValid && keyCode == KEY_STAR) m_st = S_COUNT;
        end
        default: ;
      endcase
    end
    m_sleep_out = (prev == S_DONE) && (m_st == S_DONE);
    model_push(cyc + 1);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    model_edge();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive(input logic [4:0] en, input int n);
    {init, enAutoSetting, enManualSetting, enSleep, enCancel} = en;
    repeat (n) step();
    {init, enAutoSetting, enManualSetting, enSleep, enCancel} = EN_NONE;
  endtask

  task automatic press(input logic [3:0] code);
    keyValid = 1'b1;
    keyCode = code;
    step();
    keyValid = 1'b0;
    keyCode = 4'h0;
  endtask

  task automatic random_cycle();
    logic [4:0] en;
    en = EN_NONE;
    if ($urandom_range(0, 99) < 2)  en = en | EN_INIT;
    if ($urandom_range(0, 99) < 10) en = en | EN_AUTO;
    if ($urandom_range(0, 99) < 10) en = en | EN_MAN;
    if ($urandom_range(0, 99) < 20) en = en | EN_SLEEP;
    if ($urandom_range(0, 99) < 4)  en = en | EN_CANCEL;
    {init, enAutoSetting, enManualSetting, enSleep, enCancel} = en;
    keyValid = 1'($urandom_range(0, 1));
    keyCode = 4'($urandom_range(0, 15));
    step();
    {init, enAutoSetting, enManualSetting, enSleep, enCancel} = EN_NONE;
    keyValid = 1'b0;
    keyCode = 4'h0;
  endtask

  // Assert reset between clock edges, hold it two cycles, release on a falling edge.
  task automatic async_reset();
    #3;
    reset = 1'b0;
    model_clear();
    m_sleep_out = 1'b0;
    model_push(cyc);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] prev_vec, now_vec, exp_vec;
    int unsigned exp_stamp;
    string nm;
    prev_vec = '1;
    forever begin
      @(negedge clock or negedge reset);
      #1;
      now_vec = {completeSetting, completeSleep, minLeft, secLeft, stateDbg};
      if (now_vec !== prev_vec) begin
        tests++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change: got %0d:%0d cs=%0b sl=%0b st=%0d at cycle %0d, required no change",
                   now_vec[15:9], now_vec[8:3], now_vec[17], now_vec[16], now_vec[2:0], cyc);
        end else begin
          exp_vec = exp_q.pop_front();
          exp_stamp = stamp_q.pop_front();
          nm = name_q.pop_front();
          if (now_vec !== exp_vec || cyc != exp_stamp) begin
            failures++;
            $display("FAIL %s: got %0d:%0d cs=%0b sl=%0b st=%0d at cycle %0d, required %0d:%0d cs=%0b sl=%0b st=%0d at cycle %0d",
                     nm, now_vec[15:9], now_vec[8:3], now_vec[17], now_vec[16], now_vec[2:0], cyc,
                     exp_vec[15:9], exp_vec[8:3], exp_vec[17], exp_vec[16], exp_vec[2:0], exp_stamp);
          end
        end
        prev_vec = now_vec;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    #1;
    reset = 1'b0;
    model_push(cyc);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Auto path, held enables, full countdown to DONE.
    phase = "auto_path";
    drive(EN_AUTO, 3);
    idle(2);
    drive(EN_SLEEP, 3);
    idle(485);
    phase = "done_hold";
    press(4'd5);
    press(KEY_STAR);
    drive(EN_SLEEP, 2);
    drive(EN_CANCEL, 1);

    // Manual entry, rejects and range check.
    phase = "manual_23";
    drive(EN_MAN, 1);
    press(4'd1); press(4'd2); press(4'd3); press(KEY_SHARP);
    idle(2);
    drive(EN_CANCEL, 1);
    phase = "manual_reject";
    drive(EN_MAN, 1);
    press(4'd0); press(KEY_SHARP);
    press(4'd7); press(4'd5); press(KEY_SHARP);
    press(4'hE);
    phase = "manual_accept_4";
    press(KEY_STAR); press(4'd4); press(KEY_SHARP);
    idle(2);
    drive(EN_INIT, 1);

    // Cancel on a tick edge, then a held enSleep must not restart.
    phase = "cancel_on_tick";
    drive(EN_AUTO, 1);
    drive(EN_SLEEP, 1);
    idle(119);
    drive(EN_SLEEP | EN_CANCEL, 1);
    phase = "held_sleep";
    drive(EN_SLEEP, 5);

    // Asynchronous reset mid-count.
    phase = "async_reset";
    drive(EN_AUTO, 1);
    drive(EN_SLEEP, 1);
    idle($urandom_range(10, 200));
    async_reset();
    idle(3);

    // '*' during COUNT: pauses only when the pause build is selected.
    phase = "star_in_count";
    drive(EN_AUTO, 1);
    drive(EN_SLEEP, 1);
    idle(39);
    press(KEY_STAR);
    idle(39);
    press(KEY_STAR);
    idle(450);
    drive(EN_CANCEL, 1);

    // Randomised entries and enable/key mixes.
    phase = "random";
    for (int it = 0; it < 10; it++) begin
      int nk;
      drive(EN_MAN, 1);
      nk = $urandom_range(1, 4);
      for (int k = 0; k < nk; k++) press(4'($urandom_range(0, 15)));
      press(KEY_SHARP);
      if (m_st == S_READY) begin
        drive(EN_SLEEP, 1);
        idle($urandom_range(1, 60));
      end
      for (int c = 0; c < 16; c++) random_cycle();
      drive(EN_CANCEL, 1);
    end

    idle(5);
    while (exp_q.size() > 0) begin
      logic [W-1:0] miss_vec;
      int unsigned miss_stamp;
      string miss_nm;
      miss_vec = exp_q.pop_front();
      miss_stamp = stamp_q.pop_front();
      miss_nm = name_q.pop_front();
      tests++;
      failures++;
      $display("FAIL %s: got no change, required %0d:%0d cs=%0b sl=%0b st=%0d at cycle %0d",
               miss_nm, miss_vec[15:9], miss_vec[8:3], miss_vec[17], miss_vec[16], miss_vec[2:0], miss_stamp);
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/nap_timer.md
# nap_timer

Duration-setting and countdown responder for the power-nap controller. Consumes the main FSM's phase enables (`init`, `enAutoSetting`, `enManualSetting`, `enSleep`, `enCancel`) and keypad events, and returns `completeSetting` and `completeSleep`. Holds the nap length (auto default or keypad-entered minutes), counts it down in real time, and exposes the remaining minutes and seconds for the display.

## Interface
- `CLK_HZ`, default 1000: clock cycles per second. The prescaler divides by this value. Minimum 2.
- `AUTO_MIN`, default 20: nap length in minutes loaded by auto setting. Range 1..`MAX_MIN`.
- `MAX_MIN`, default 99: largest accepted manual entry, in minutes.
- `clock` input, 1 bit: system clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low. All state and outputs clear while low.
- `init` input, 1 bit: level. Return to IDLE.
- `enAutoSetting` input, 1 bit: level. Request auto duration.
- `enManualSetting` input, 1 bit: level. Request keypad entry.
- `enSleep` input, 1 bit: level. Start the countdown.
- `enCancel` input, 1 bit: level. Abort to IDLE.
- `keyValid` input, 1 bit: one-cycle strobe qualifying `keyCode`.
- `keyCode` input, 4 bits: 0–9 are digits, 4'hA is `*` (clear/pause), 4'hB is `#` (enter). Other codes are ignored.
- `completeSetting` output, 1 bit: registered level, high in READY.
- `completeSleep` output, 1 bit: registered level, high in DONE.
- `minLeft` output, 7 bits: remaining minutes. Shows the entry buffer during MANUAL.
- `secLeft` output, 6 bits: remaining seconds, 0..59.

## Operation
- States: IDLE, MANUAL, READY, COUNT, DONE (plus PAUSE if configured).
- Enable priority, evaluated every cycle: `init`|`enCancel` > `enSleep` > `enManualSetting` > `enAutoSetting`. Enables are levels; a held enable never retriggers a completed action.
- `init` or `enCancel` in any state: go to IDLE and clear the buffer, duration, counters and prescaler. Outputs read 0 on the next cycle.
- IDLE:
  - `enAutoSetting` → duration=`AUTO_MIN`, go to READY.
  - `enManualSetting` → buffer=0, go to MANUAL.
- MANUAL:
  - Digit d → buffer=(buffer mod 10)*10+d. The buffer keeps the last two digits.
  - `*` → buffer=0.
  - `#` with buffer in 1..`MAX_MIN` → duration=buffer, go to READY.
  - `#` with buffer 0 or >`MAX_MIN` → ignored; buffer cleared, stay in MANUAL.
- READY: `enSleep` → min=duration, sec=0, prescaler=0, go to COUNT.
- COUNT: on each tick:
  - If sec=0: sec=59, min=min−1. Otherwise sec=sec−1.
  - If the result is 0:00, go to DONE on the same edge.
- DONE: hold 0:00 until `init` or `enCancel`. Keys are ignored.
- Keys in IDLE, READY and DONE are ignored. In COUNT, keys are ignored unless pause is configured.
- Arithmetic is unsigned. Minute decrement never underflows because 0:00 exits COUNT.

## Timing
- Reset values: `completeSetting`=0, `completeSleep`=0, `minLeft`=0, `secLeft`=0, state IDLE.
- `completeSetting` goes high the cycle after the edge that samples `enAutoSetting` or an accepted `#`.
- Tick is a one-cycle pulse every `CLK_HZ` cycles, counted from COUNT entry. The first tick comes `CLK_HZ` cycles after the `enSleep` sample edge.
- `completeSleep` goes high exactly duration×60×`CLK_HZ` cycles after the `enSleep` sample edge, plus 1 cycle of output register.
- A tick coinciding with `enCancel`: cancel wins and no decrement is applied.
- `keyValid` coinciding with a state change: the key is evaluated in the old state only.
- Reset asserted mid-COUNT: immediate clear. After release, the first active edge sees IDLE.

## Configuration
- `NAP_PAUSE_EN` defined:
  - In COUNT, `*` → PAUSE: prescaler and counters frozen, `completeSetting`/`completeSleep` stay 0.
  - In PAUSE, `*` → COUNT, resuming with the prescaler value preserved.
  - `init`/`enCancel` exit PAUSE to IDLE.
- `NAP_PAUSE_EN` undefined: no PAUSE state; `*` is ignored in COUNT.

## Structure
- Shared package `nap_pkg`:
  - State enum.
  - Key code constants `KEY_STAR`=4'hA and `KEY_SHARP`=4'hB.
  - Seconds-per-minute constant 60.
- Sub-module `nap_prescaler`:
  - Parameter `CLK_HZ`.
  - Inputs: `clock`, `reset`, `clear`, `run`.
  - Output: `tick`.
  - Counter width is $clog2(`CLK_HZ`).
- Top-level `nap_timer` holds the FSM, the entry buffer, and the min/sec counters.

## Test plan
Benches use `CLK_HZ`=4 and `AUTO_MIN`=2.
- Auto path: `enAutoSetting` pulse → `completeSetting`=1 next cycle. `enSleep` → `minLeft`=2, `secLeft`=0, then 1:59 after 4 cycles. `completeSleep`=1 exactly 481 cycles after the `enSleep` sample.
- Manual entry: keys 1, 2, 3, `#` → buffer 23, duration 23, `completeSetting`=1. Keys 0, `#` → stays MANUAL, `completeSetting`=0.
- Range check with `MAX_MIN`=50: keys 7, 5, `#` → rejected, buffer 0. Keys `*`, 4, `#` → accepted, `minLeft`=4.
- Cancel mid-count at 1:30 → next cycle all outputs 0, state IDLE. A held `enSleep` does not restart the count.
- Async reset low mid-COUNT, between clock edges → outputs 0 immediately.
- With `NAP_PAUSE_EN`: `*` at 1:50, hold 40 cycles → still 1:50. `*` again → `completeSleep` is delayed by exactly 40 cycles versus the unpaused run.
